// File: rtl/mem_dump_ctrl_if.sv
// Debug memory read port plus byte stream toward the debug UART TX.
// master = dump sequencer, slave = memory/TX side.
interface mem_dump_ctrl_if #(
    parameter int B = 32
);
    logic [B-1:0] o_debug_addr;
    logic [B-1:0] i_debug_data;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         i_tx_ready;

    modport master (
        output o_debug_addr,
        input  i_debug_data,
        output o_tx_data,
        output o_tx_valid,
        input  i_tx_ready
    );

    modport slave (
        input  o_debug_addr,
        output i_debug_data,
        input  o_tx_data,
        input  o_tx_valid,
        output i_tx_ready
    );
endinterface

// File: rtl/mem_dump_ctrl.sv
// Walks a word-address range on the data memory debug port and streams each
// word MSB-first as bytes over a valid/ready link to the debug UART.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | address presented, waiting out the memory read latency
// SEND   | shifting the captured word out byte by byte
// DONE   | one-cycle completion pulse
module mem_dump_ctrl #(
    parameter int B      = 32,
    parameter int W      = 10,
    parameter int RD_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [W-3:0]        i_base,
    input  logic [W-2:0]        i_count,
    output logic                o_busy,
    output logic                o_done,
    mem_dump_ctrl_if.master     bus
);
    localparam int AW = W - 2;
    localparam int NB = B / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int LW = $clog2(RD_LAT + 2);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW:0]     rem_q, rem_d;
    logic [B-1:0]    shreg_q, shreg_d;
    logic [BW-1:0]   byte_idx_q, byte_idx_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            accept;
    logic [B-1:0]    shreg_next;

    assign accept     = tx_valid_q && bus.i_tx_ready;
    assign shreg_next = shreg_q << 8;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            shreg_q    <= '0;
            byte_idx_q <= '0;
            lat_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
            lat_q      <= lat_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort)
                    state_d = (i_count == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                if (i_abort)
                    state_d = S_IDLE;
                else if (lat_q == '0)
                    state_d = S_SEND;
            end
            S_SEND: begin
                if (i_abort)
                    state_d = S_IDLE;
                else if (accept && byte_idx_q == '0)
                    state_d = (rem_q > (AW+1)'(1)) ? S_READ : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read wait is RD_LAT+2 cycles: the read latency plus one settle cycle
    // before capture, so the first byte appears RD_LAT+2 edges after start.
    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        shreg_d    = shreg_q;
        byte_idx_d = byte_idx_q;
        lat_d      = lat_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    rem_d = i_count;
                    lat_d = LW'(RD_LAT + 1);
                    if (i_count != '0)
                        addr_d = i_base;
                end
            end
            S_READ: begin
                if (!i_abort) begin
                    if (lat_q == '0) begin
                        shreg_d    = bus.i_debug_data;
                        tx_data_d  = bus.i_debug_data[B-1 -: 8];
                        tx_valid_d = 1'b1;
                        byte_idx_d = BW'(NB - 1);
                    end else begin
                        lat_d = lat_q - 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (i_abort) begin
                    tx_valid_d = 1'b0;
                end else if (accept) begin
                    if (byte_idx_q == '0) begin
                        tx_valid_d = 1'b0;
                        rem_d      = rem_q - 1'b1;
                        if (rem_q > (AW+1)'(1)) begin
                            addr_d = addr_q + 1'b1;
                            lat_d  = LW'(RD_LAT + 1);
                        end
                    end else begin
                        byte_idx_d = byte_idx_q - 1'b1;
                        shreg_d    = shreg_next;
                        tx_data_d  = shreg_next[B-1 -: 8];
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_busy = (state_q != S_IDLE);
        o_done = (state_q == S_DONE);
    end

    assign bus.o_debug_addr = B'(addr_q);
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_tx_valid   = tx_valid_q;
endmodule
